alu_arbiter: RTL

- Shares the single registered 16-bit ALU between two requesters: requester 0 is the main control FSM, requester 1 is the stack/address unit.
- Accepts one operation at a time, using round-robin arbitration.
- Drives the ALU's SrcA/SrcB/AluOp selects and captures the ALU's registered result, which is overwritten every cycle.
- Returns the result to the winning requester over a valid/ready handshake.

---
 rtl/alu_arb_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/alu_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_e;

  typedef enum logic {SRCA_MARY, SRCA_SP} srca_e;
  typedef enum logic [1:0] {SRCB_SHELLEY, SRCB_ZEXT, SRCB_SEXT, SRCB_SEXT_LS} srcb_e;

  localparam logic [ALU_OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 4'b0011;
  localparam logic [ALU_OP_W-1:0] OP_SLT = 4'b0100;
  localparam logic [ALU_OP_W-1:0] OP_SGT = 4'b0101;
  localparam logic [ALU_OP_W-1:0] OP_SEQ = 4'b0110;
  localparam logic [ALU_OP_W-1:0] OP_SHL = 4'b1000;
  localparam logic [ALU_OP_W-1:0] OP_SHR = 4'b1001;

  function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SGT, OP_SEQ, OP_SHL, OP_SHR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: a lone valid wins, a tie goes to the
// requester that did not win last. mask removes requesters from the contest.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] v;

  always_comb begin
    v     = valid & mask;
    grant = 2'b00;
    case (v)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between the control FSM (req 0) and the stack unit
// (req 1). Define ALU_ARB_LOCK_EN to add req_lock and bounded locked grants.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = ALU_OP_W
`ifdef ALU_ARB_LOCK_EN
  ,
  parameter int LOCK_MAX = 4
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic              req0_src_a,
  input  logic              req1_src_a,
  input  logic [1:0]        req0_src_b,
  input  logic [1:0]        req1_src_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [OP_W-1:0]   req1_op,
`ifdef ALU_ARB_LOCK_EN
  input  logic [1:0]        req_lock,
`endif
  output logic              SrcA,
  output logic [1:0]        SrcB,
  output logic [OP_W-1:0]   AluOp,
  input  logic [DATA_W-1:0] alu_out,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_illegal,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_idx_q, grant_idx_d;
  logic                sel_a_q, sel_a_d;
  logic [1:0]          sel_b_q, sel_b_d;
  logic [OP_W-1:0]     sel_op_q, sel_op_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_illegal_q, rsp_illegal_d;

  logic [1:0] grant, lock_mask;
  logic       accept, win_idx;

  assign req_ready = (state_q == IDLE) ? grant : 2'b00;
  assign accept    = |(req_ready & req_valid);
  assign win_idx   = req_ready[1];

`ifdef ALU_ARB_LOCK_EN
  localparam int LCW = $clog2(LOCK_MAX + 1);

  logic           lock_on_q, lock_on_d;
  logic           lock_own_q, lock_own_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           lock_hold;

  // The lock only bites while its holder is actually asking for the ALU.
  assign lock_hold = lock_on_q && req_valid[lock_own_q];
  assign lock_mask = lock_hold ? (lock_own_q ? 2'b10 : 2'b01) : 2'b11;

  always_comb begin
    lock_on_d  = lock_on_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    if (state_q == IDLE) begin
      if (lock_on_q && !req_valid[lock_own_q]) begin
        lock_on_d  = 1'b0;
        lock_cnt_d = '0;
      end
      if (accept) begin
        if (!req_lock[win_idx]) begin
          lock_on_d  = 1'b0;
          lock_cnt_d = '0;
        end else begin
          lock_own_d = win_idx;
          lock_cnt_d = lock_hold ? lock_cnt_q + 1'b1 : LCW'(1);
          lock_on_d  = (lock_cnt_d != LCW'(LOCK_MAX));
          if (!lock_on_d) lock_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_on_q  <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      lock_on_q  <= lock_on_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  assign lock_mask = 2'b11;
`endif

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .mask       (lock_mask),
    .grant      (grant)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_idx_d   = grant_idx_q;
    sel_a_d       = sel_a_q;
    sel_b_d       = sel_b_q;
    sel_op_d      = sel_op_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_illegal_d = rsp_illegal_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d      = EXEC;
        grant_idx_d  = win_idx;
        last_grant_d = win_idx;
        sel_a_d      = win_idx ? req1_src_a : req0_src_a;
        sel_b_d      = win_idx ? req1_src_b : req0_src_b;
        sel_op_d     = win_idx ? req1_op    : req0_op;
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        // alu_out now reflects the selects driven during EXEC.
        state_d       = RESP;
        rsp_illegal_d = !is_legal_op(sel_op_q);
        rsp_data_d    = rsp_illegal_d ? '0 : alu_out;
        rsp_valid_d   = grant_idx_q ? 2'b10 : 2'b01;
        sel_a_d       = SRCA_MARY;
        sel_b_d       = SRCB_SHELLEY;
        sel_op_d      = '0;
      end
      RESP: if (rsp_ready[grant_idx_q]) begin
        state_d     = IDLE;
        rsp_valid_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_idx_q   <= 1'b0;
      sel_a_q       <= 1'b0;
      sel_b_q       <= 2'b00;
      sel_op_q      <= '0;
      rsp_valid_q   <= 2'b00;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_idx_q   <= grant_idx_d;
      sel_a_q       <= sel_a_d;
      sel_b_q       <= sel_b_d;
      sel_op_q      <= sel_op_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign SrcA        = sel_a_q;
  assign SrcB        = sel_b_q;
  assign AluOp       = sel_op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_illegal = rsp_illegal_q;
  assign busy        = (state_q != IDLE);

endmodule
